wb_rr_arbiter: RTL
==================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter NUM_M, default 3, number of CPU data masters.
REQ-002 Parameter DW, default 32, data/address width.
REQ-003 Parameter TMO, default 255, max wait cycles for slave ack before error (1..255).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 m_cyc  input  NUM_M  per-master request/cycle.
REQ-007 m_we  input  NUM_M  per-master write enable.
REQ-008 m_adr  input  NUM_M*DW  per-master address, master i at bits [i*DW +: DW].
REQ-009 m_dat_o  input  NUM_M*DW  per-master write data, same packing.
REQ-010 m_dat_i  output  DW  read data broadcast to all masters.
REQ-011 m_ack  output  NUM_M  per-master ack, one-hot or zero.
REQ-012 m_err  output  NUM_M  per-master timeout error, one-hot or zero.
REQ-013 s_cyc, s_stb, s_we  output  1 each  slave bus controls.
REQ-014 s_adr, s_dat_o  output  DW each  slave address/write data.
REQ-015 s_dat_i  input  DW  slave read data; s_ack  input  1  slave ack.
REQ-016 err_src  output  2  index of master last timed out; err_vld output 1 sticky flag, cleared only by reset.

Function
REQ-017 FSM states IDLE, BUSY; owner register own (2 bits), last-grant pointer lg (2 bits).
REQ-018 IDLE with any m_cyc set: grant first requester scanning from lg+1 upward modulo NUM_M; next cycle own=winner, lg=winner, state BUSY.
REQ-019 IDLE with no request: remain IDLE, s_cyc=s_stb=0.
REQ-020 BUSY: s_cyc=s_stb=m_cyc[own]; s_we, s_adr, s_dat_o from owner; all other slave outputs zero-muxed when not BUSY.
REQ-021 BUSY and s_ack: m_ack[own]=1 same cycle (combinational), m_dat_i=s_dat_i; next state IDLE.
REQ-022 Minimum one IDLE cycle between consecutive grants; back-to-back requesters alternate per REQ-018.
REQ-023 Wait counter (8 bits) clears on entering BUSY, increments each BUSY cycle without s_ack.
REQ-024 Counter reaching TMO without s_ack: m_err[own]=1 for that cycle, s_cyc=0 that cycle, err_src=own, err_vld=1, next state IDLE.
REQ-025 s_ack and timeout in same cycle: ack wins, no error.
REQ-026 Owner drops m_cyc in BUSY: abort, no ack/err, next state IDLE; slave s_ack that cycle ignored.
REQ-027 Requests from non-owners in BUSY are held; never preempt owner.
REQ-028 m_ack and m_err never both set; at most one bit set in each.
REQ-029 m_dat_i = s_dat_i only during owner ack, else zero.

Reset
REQ-030 rst_n low asynchronously forces state IDLE, own=0, lg=NUM_M-1 (so master 0 wins first), counter 0, err_src 0, err_vld 0.
REQ-031 During and after reset all outputs 0 until a grant; reset mid-BUSY drops s_cyc immediately with no ack/err.

Structure
REQ-032 Shared package holds NUM_M, DW, TMO defaults, state encoding, counter width.
REQ-033 One sub-module rr_pick: combinational round-robin priority picker (req vector, lg in; winner index, valid out).
REQ-034 Registered FSM/counter in top; slave mux and ack/err demux combinational from own.

Verification
REQ-035 Reset then m_cyc=3'b001, adr 0x100, slave acks after 2 cycles -> s_cyc high from cycle 1, m_ack[0] with s_dat_i 0xDEADBEEF on cycle 3.
REQ-036 m_cyc=3'b111 held, slave acks each 1 cycle -> grant order 0,1,2,0 with one idle cycle between.
REQ-037 Owner 1 granted, slave never acks, TMO=4 -> m_err[1] on 4th wait cycle, err_src=1, err_vld=1, then master 2 grants next.
REQ-038 s_ack coincident with TMO expiry -> m_ack only, err_vld stays 0.
REQ-039 Owner 0 drops m_cyc mid-BUSY while 2 requests -> no ack, IDLE, then master 2 granted.
REQ-040 rst_n low during BUSY -> s_cyc falls asynchronously, lg=2, next grant to master 0.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared defaults and encodings for the round-robin Wishbone arbiter.
package wb_rr_arbiter_pkg;

  localparam int NUM_M_DEF = 3;
  localparam int DW_DEF    = 32;
  localparam int TMO_DEF   = 255;
  localparam int CNT_W     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above the last grant, wrapping.
module rr_pick #(
  parameter int NUM_M = 3
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [1:0]       lg_i,
  output logic [1:0]       win_o,
  output logic             vld_o
);

  // Outer loop walks the priority order lg+1, lg+2, ... lg+NUM_M (mod NUM_M).
  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    for (int i = 1; i <= NUM_M; i++) begin
      for (int j = 0; j < NUM_M; j++) begin
        if (!vld_o && req_i[j] && (j == ((int'(lg_i) + i) % NUM_M))) begin
          win_o = 2'(j);
          vld_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between CPU data masters,
// with a per-transaction ack timeout that reports the offending master.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_M = NUM_M_DEF,
  parameter int DW    = DW_DEF,
  parameter int TMO   = TMO_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_M-1:0]    m_cyc,
  input  logic [NUM_M-1:0]    m_we,
  input  logic [NUM_M*DW-1:0] m_adr,
  input  logic [NUM_M*DW-1:0] m_dat_o,
  output logic [DW-1:0]       m_dat_i,
  output logic [NUM_M-1:0]    m_ack,
  output logic [NUM_M-1:0]    m_err,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [DW-1:0]       s_adr,
  output logic [DW-1:0]       s_dat_o,
  input  logic [DW-1:0]       s_dat_i,
  input  logic                s_ack,
  output logic [1:0]          err_src,
  output logic                err_vld
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

  state_e           state_q, state_d;
  logic [1:0]       own_q, own_d;
  logic [1:0]       lg_q, lg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_src_q, err_src_d;
  logic             err_vld_q, err_vld_d;

  logic [1:0]       pick_win;
  logic             pick_vld;
  logic [NUM_M-1:0] own_oh;
  logic             own_cyc;
  logic             own_we;
  logic [DW-1:0]    own_adr;
  logic [DW-1:0]    own_dat;

  rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req_i (m_cyc),
    .lg_i  (lg_q),
    .win_o (pick_win),
    .vld_o (pick_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      own_q     <= '0;
      lg_q      <= 2'(NUM_M - 1);
      cnt_q     <= '0;
      err_src_q <= '0;
      err_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      lg_q      <= lg_d;
      cnt_q     <= cnt_d;
      err_src_q <= err_src_d;
      err_vld_q <= err_vld_d;
    end
  end

  always_comb begin
    own_oh  = '0;
    own_cyc = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    for (int j = 0; j < NUM_M; j++) begin
      if (own_q == 2'(j)) begin
        own_oh[j] = 1'b1;
        own_cyc   = m_cyc[j];
        own_we    = m_we[j];
        own_adr   = m_adr[j*DW +: DW];
        own_dat   = m_dat_o[j*DW +: DW];
      end
    end
  end

  // Outcome priority in BUSY: owner abort, then ack, then timeout.
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    lg_d      = lg_q;
    cnt_d     = cnt_q;
    err_src_d = err_src_q;
    err_vld_d = err_vld_q;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_o   = '0;
    m_ack     = '0;
    m_err     = '0;
    m_dat_i   = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          own_d   = pick_win;
          lg_d    = pick_win;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_cyc   = own_cyc;
        s_stb   = own_cyc;
        s_we    = own_we;
        s_adr   = own_adr;
        s_dat_o = own_dat;
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (s_ack) begin
          m_ack   = own_oh;
          m_dat_i = s_dat_i;
          state_d = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          m_err     = own_oh;
          s_cyc     = 1'b0;
          s_stb     = 1'b0;
          err_src_d = own_q;
          err_vld_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_src = err_src_q;
  assign err_vld = err_vld_q;

endmodule
